// File: rtl/ddr3_pkg.sv
// rtl/ddr3_pkg.sv - shared types and constants for the DDR3 init sequencer
//
// Contents:
//   state_t       init sequencer states
//   CMD_*         command codes packed as {csn, rasn, casn, wen}
//   MR*_IDX       bank-address values selecting each mode register
//   ZQCL_A        address bus value for ZQCL (A10 = long calibration)
//   max2          helper used to size the shared countdown
package ddr3_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RST_HOLD,
    ST_CKE_WAIT,
    ST_XPR_WAIT,
    ST_MRS2,
    ST_MRS3,
    ST_MRS1,
    ST_MRS0,
    ST_MOD_WAIT,
    ST_ZQCL,
    ST_ZQ_WAIT,
    ST_DONE
  } state_t;

  localparam logic [3:0] CMD_DESEL = 4'b1111;
  localparam logic [3:0] CMD_NOP   = 4'b0111;
  localparam logic [3:0] CMD_MRS   = 4'b0000;
  localparam logic [3:0] CMD_ZQCL  = 4'b0110;

  localparam logic [2:0] MR0_IDX = 3'd0;
  localparam logic [2:0] MR1_IDX = 3'd1;
  localparam logic [2:0] MR2_IDX = 3'd2;
  localparam logic [2:0] MR3_IDX = 3'd3;

  localparam logic [13:0] ZQCL_A = 14'h0400;

  function automatic int max2(input int x, input int y);
    return (x > y) ? x : y;
  endfunction

endpackage

// File: rtl/ddr3_cmd_drv.sv
// rtl/ddr3_cmd_drv.sv - registered DDR3 command/address output stage
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   cmd             {csn, rasn, casn, wen} for the next cycle
//   cmd_a, cmd_ba   address / bank for the next cycle
//   csn..wen        registered command pins (reset to DESELECT)
//   odt             on-die termination, tied low
//   addr, bank      registered address / bank pins (reset to 0)
module ddr3_cmd_drv
  import ddr3_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  cmd,
  input  logic [13:0] cmd_a,
  input  logic [2:0]  cmd_ba,
  output logic        csn,
  output logic        rasn,
  output logic        casn,
  output logic        wen,
  output logic        odt,
  output logic [13:0] addr,
  output logic [2:0]  bank
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {csn, rasn, casn, wen} <= CMD_DESEL;
      addr                   <= '0;
      bank                   <= '0;
    end else begin
      {csn, rasn, casn, wen} <= cmd;
      addr                   <= cmd_a;
      bank                   <= cmd_ba;
    end
  end

  assign odt = 1'b0;

endmodule

// File: rtl/ddr3_init_seq.sv
// rtl/ddr3_init_seq.sv - DDR3 power-up / initialisation sequencer
//
// Ports:
//   osc         system clock
//   rst         asynchronous active-high reset
//   start       pulse; starts (IDLE) or restarts (DONE) the sequence
//   busy        high while sequencing
//   init_done   high once ZQ calibration time has elapsed
//   ddr3_*      DRAM reset, CKE, command, ODT, address and bank pins
//
// The FSM computes the next state and the pin values that belong to it in
// one comb process; everything is registered on the same edge as the state,
// so the pins always show the values of the current state.
module ddr3_init_seq
  import ddr3_pkg::*;
#(
  parameter int          T_RESET_CYC  = 10000,
  parameter int          T_CKE_CYC    = 25000,
  parameter int          T_XPR_CYC    = 12,
  parameter int          T_MRD_CYC    = 4,
  parameter int          T_MOD_CYC    = 12,
  parameter int          T_ZQINIT_CYC = 512,
  parameter logic [13:0] MR0_VAL      = 14'h0520,
  parameter logic [13:0] MR1_VAL      = 14'h0004,
  parameter logic [13:0] MR2_VAL      = 14'h0008,
  parameter logic [13:0] MR3_VAL      = 14'h0000,
  parameter bit          AUTO_START   = 1'b1
) (
  input  logic        osc,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        init_done,
  output logic        ddr3_rstn,
  output logic        ddr3_cke,
  output logic        ddr3_csn,
  output logic        ddr3_rasn,
  output logic        ddr3_casn,
  output logic        ddr3_wen,
  output logic        ddr3_odt,
  output logic [13:0] ddr3_a,
  output logic [2:0]  ddr3_ba
);

  if (T_RESET_CYC < 1 || T_CKE_CYC < 1 || T_XPR_CYC < 1 ||
      T_MRD_CYC < 1 || T_MOD_CYC < 1 || T_ZQINIT_CYC < 1) begin : g_param_check
    $error("ddr3_init_seq: every T_*_CYC parameter must be >= 1");
  end

  localparam int T_MAX = max2(max2(max2(T_RESET_CYC, T_CKE_CYC), max2(T_XPR_CYC, T_MRD_CYC)),
                              max2(T_MOD_CYC, T_ZQINIT_CYC));
  localparam int CW = $clog2(T_MAX) + 1;

  // MR0 and ZQCL are single-cycle issue states, so their trailing waits are
  // one cycle shorter and vanish entirely when the timing is a single cycle.
  localparam logic [CW-1:0] LD_RESET = CW'(T_RESET_CYC - 1);
  localparam logic [CW-1:0] LD_CKE   = CW'(T_CKE_CYC - 1);
  localparam logic [CW-1:0] LD_XPR   = CW'(T_XPR_CYC - 1);
  localparam logic [CW-1:0] LD_MRD   = CW'(T_MRD_CYC - 1);
  localparam logic [CW-1:0] LD_MOD   = CW'((T_MOD_CYC > 1) ? T_MOD_CYC - 2 : 0);
  localparam logic [CW-1:0] LD_ZQ    = CW'((T_ZQINIT_CYC > 1) ? T_ZQINIT_CYC - 2 : 0);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          enter;
  logic          auto_pend;

  logic [3:0]    cmd_nxt;
  logic [13:0]   a_nxt;
  logic [2:0]    ba_nxt;
  logic          rstn_nxt, cke_nxt, busy_nxt, done_nxt;

  always_ff @(posedge osc or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      auto_pend <= AUTO_START;
      busy      <= 1'b0;
      init_done <= 1'b0;
      ddr3_rstn <= 1'b0;
      ddr3_cke  <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      auto_pend <= 1'b0;
      busy      <= busy_nxt;
      init_done <= done_nxt;
      ddr3_rstn <= rstn_nxt;
      ddr3_cke  <= cke_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    enter     = 1'b0;
    cnt_nxt   = (cnt != '0) ? cnt - CW'(1) : cnt;

    case (state)
      ST_IDLE:     if (start || auto_pend) begin state_nxt = ST_RST_HOLD; enter = 1'b1; end
      ST_DONE:     if (start) begin state_nxt = ST_RST_HOLD; enter = 1'b1; end
      ST_RST_HOLD: if (cnt == '0) begin state_nxt = ST_CKE_WAIT; enter = 1'b1; end
      ST_CKE_WAIT: if (cnt == '0) begin state_nxt = ST_XPR_WAIT; enter = 1'b1; end
      ST_XPR_WAIT: if (cnt == '0) begin state_nxt = ST_MRS2; enter = 1'b1; end
      ST_MRS2:     if (cnt == '0) begin state_nxt = ST_MRS3; enter = 1'b1; end
      ST_MRS3:     if (cnt == '0) begin state_nxt = ST_MRS1; enter = 1'b1; end
      ST_MRS1:     if (cnt == '0) begin state_nxt = ST_MRS0; enter = 1'b1; end
      ST_MRS0: begin
        state_nxt = (T_MOD_CYC > 1) ? ST_MOD_WAIT : ST_ZQCL;
        enter     = 1'b1;
      end
      ST_MOD_WAIT: if (cnt == '0) begin state_nxt = ST_ZQCL; enter = 1'b1; end
      ST_ZQCL: begin
        state_nxt = (T_ZQINIT_CYC > 1) ? ST_ZQ_WAIT : ST_DONE;
        enter     = 1'b1;
      end
      ST_ZQ_WAIT:  if (cnt == '0) begin state_nxt = ST_DONE; enter = 1'b1; end
      default:     begin state_nxt = ST_IDLE; enter = 1'b1; end
    endcase

    if (enter) begin
      case (state_nxt)
        ST_RST_HOLD:                cnt_nxt = LD_RESET;
        ST_CKE_WAIT:                cnt_nxt = LD_CKE;
        ST_XPR_WAIT:                cnt_nxt = LD_XPR;
        ST_MRS2, ST_MRS3, ST_MRS1:  cnt_nxt = LD_MRD;
        ST_MOD_WAIT:                cnt_nxt = LD_MOD;
        ST_ZQ_WAIT:                 cnt_nxt = LD_ZQ;
        default:                    cnt_nxt = '0;
      endcase
    end

    // Pin values for the cycle spent in state_nxt.
    cmd_nxt  = CMD_NOP;
    a_nxt    = '0;
    ba_nxt   = '0;
    rstn_nxt = 1'b1;
    cke_nxt  = 1'b1;
    busy_nxt = 1'b1;
    done_nxt = 1'b0;

    case (state_nxt)
      ST_IDLE: begin
        cmd_nxt  = CMD_DESEL;
        rstn_nxt = 1'b0;
        cke_nxt  = 1'b0;
        busy_nxt = 1'b0;
      end
      ST_RST_HOLD: begin
        cmd_nxt  = CMD_DESEL;
        rstn_nxt = 1'b0;
        cke_nxt  = 1'b0;
      end
      ST_CKE_WAIT: begin
        cmd_nxt = CMD_DESEL;
        cke_nxt = 1'b0;
      end
      ST_DONE: begin
        busy_nxt = 1'b0;
        done_nxt = 1'b1;
      end
      default: ;
    endcase

    // Commands go out only on the first cycle of their state.
    if (enter) begin
      case (state_nxt)
        ST_MRS2: begin cmd_nxt = CMD_MRS;  ba_nxt = MR2_IDX; a_nxt = MR2_VAL; end
        ST_MRS3: begin cmd_nxt = CMD_MRS;  ba_nxt = MR3_IDX; a_nxt = MR3_VAL; end
        ST_MRS1: begin cmd_nxt = CMD_MRS;  ba_nxt = MR1_IDX; a_nxt = MR1_VAL; end
        ST_MRS0: begin cmd_nxt = CMD_MRS;  ba_nxt = MR0_IDX; a_nxt = MR0_VAL; end
        ST_ZQCL: begin cmd_nxt = CMD_ZQCL; a_nxt = ZQCL_A; end
        default: ;
      endcase
    end
  end

  ddr3_cmd_drv u_cmd_drv (
    .clk    (osc),
    .rst    (rst),
    .cmd    (cmd_nxt),
    .cmd_a  (a_nxt),
    .cmd_ba (ba_nxt),
    .csn    (ddr3_csn),
    .rasn   (ddr3_rasn),
    .casn   (ddr3_casn),
    .wen    (ddr3_wen),
    .odt    (ddr3_odt),
    .addr   (ddr3_a),
    .bank   (ddr3_ba)
  );

endmodule

// File: tb/tb_ddr3_init_seq.sv
// tb/tb_ddr3_init_seq.sv - scoreboard bench for ddr3_init_seq
module tb_ddr3_init_seq;

  typedef struct {
    int         cyc;
    logic [3:0] cmd;
    logic [2:0] ba;
    logic [13:0] a;
  } exp_t;

  logic osc = 1'b0;
  logic rst, start, rst2, start2;
  logic busy, init_done, rstn, cke, csn, rasn, casn, wen, odt;
  logic [13:0] a;
  logic [2:0]  ba;
  logic busy2, done2, rstn2, cke2, csn2, rasn2, casn2, wen2, odt2;
  logic [13:0] a2;
  logic [2:0]  ba2;

  int   cyc = 0;
  int   t0 = 0;
  int   mode = 0;
  int   total = 0;
  int   bad = 0;
  exp_t sb_q[$];

  always #10 osc = ~osc;
  always @(posedge osc) cyc <= cyc + 1;

  ddr3_init_seq #(
    .T_RESET_CYC(8), .T_CKE_CYC(10), .T_XPR_CYC(5), .T_MRD_CYC(4),
    .T_MOD_CYC(12), .T_ZQINIT_CYC(16), .AUTO_START(1'b0)
  ) dut (
    .osc(osc), .rst(rst), .start(start), .busy(busy), .init_done(init_done),
    .ddr3_rstn(rstn), .ddr3_cke(cke), .ddr3_csn(csn), .ddr3_rasn(rasn),
    .ddr3_casn(casn), .ddr3_wen(wen), .ddr3_odt(odt), .ddr3_a(a), .ddr3_ba(ba)
  );

  ddr3_init_seq #(
    .T_RESET_CYC(8), .T_CKE_CYC(10), .T_XPR_CYC(5), .T_MRD_CYC(4),
    .T_MOD_CYC(12), .T_ZQINIT_CYC(16), .AUTO_START(1'b1)
  ) dut_auto (
    .osc(osc), .rst(rst2), .start(start2), .busy(busy2), .init_done(done2),
    .ddr3_rstn(rstn2), .ddr3_cke(cke2), .ddr3_csn(csn2), .ddr3_rasn(rasn2),
    .ddr3_casn(casn2), .ddr3_wen(wen2), .ddr3_odt(odt2), .ddr3_a(a2), .ddr3_ba(ba2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge osc);
    #1;
  endtask

  task automatic wait_to(input int target);
    while (cyc < target) tick();
  endtask

  // Drive a one-cycle start pulse; when it should trigger, record the
  // trigger cycle and queue the five commands it must produce.
  task automatic do_start(input bit trig);
    start = 1'b1;
    if (trig) begin
      t0   = cyc;
      mode = 1;
      sb_q.push_back('{t0 + 24, 4'b0000, 3'd2, 14'h0008});
      sb_q.push_back('{t0 + 28, 4'b0000, 3'd3, 14'h0000});
      sb_q.push_back('{t0 + 32, 4'b0000, 3'd1, 14'h0004});
      sb_q.push_back('{t0 + 36, 4'b0000, 3'd0, 14'h0520});
      sb_q.push_back('{t0 + 48, 4'b0110, 3'd0, 14'h0400});
    end
    tick();
    start = 1'b0;
  endtask

  // Per-cycle monitor on the falling edge.
  always @(negedge osc) begin
    int   rel;
    bit   skip;
    logic e_rstn, e_cke, e_busy, e_done;
    logic [3:0] bus;
    exp_t e;
    skip = 1'b0;
    rel  = cyc - t0;
    bus  = {csn, rasn, casn, wen};
    if (mode == 0) begin
      e_rstn = 0; e_cke = 0; e_busy = 0; e_done = 0;
    end else begin
      skip   = (rel == 0);
      e_rstn = (rel >= 9);
      e_cke  = (rel >= 19);
      e_busy = (rel < 64);
      e_done = (rel >= 64);
    end
    if (!skip) begin
      check("rstn", rstn, e_rstn);
      check("cke", cke, e_cke);
      check("busy", busy, e_busy);
      check("init_done", init_done, e_done);
      check("odt", odt, 1'b0);
      while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
        e = sb_q.pop_front();
        check("missed_cmd_cyc", cyc, e.cyc);
      end
      if (!csn && {rasn, casn, wen} != 3'b111) begin
        if (sb_q.size() == 0) begin
          check("unexpected_cmd", bus, e_cke ? 4'b0111 : 4'b1111);
        end else begin
          e = sb_q.pop_front();
          check("cmd_cyc", cyc, e.cyc);
          check("cmd_code", bus, e.cmd);
          check("cmd_ba", ba, e.ba);
          check("cmd_a", a, e.a);
        end
      end else begin
        check("idle_bus", bus, e_cke ? 4'b0111 : 4'b1111);
      end
    end
  end

  initial begin
    int k;
    int rel;
    rst = 1'b1; start = 1'b0; rst2 = 1'b1; start2 = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    repeat (3) tick();

    // basic sequence with ignored starts while busy, then restart from DONE
    do_start(1'b1);
    wait_to(t0 + 15);
    do_start(1'b0);
    wait_to(t0 + 40);
    do_start(1'b0);
    wait_to(t0 + 70);
    do_start(1'b1);
    wait_to(t0 + 80);
    check("cmd_q_left_a", sb_q.size(), 0);

    // reset in the middle of a sequence, then a fresh start
    do_start(1'b1);
    wait_to(t0 + 30);
    rst  = 1'b1;
    mode = 0;
    sb_q.delete();
    repeat (2) tick();
    rst = 1'b0;
    repeat (2) tick();
    do_start(1'b1);
    wait_to(t0 + 70);
    check("cmd_q_left_b", sb_q.size(), 0);

    // auto start, with start coinciding with the auto trigger cycle
    rst2   = 1'b0;
    start2 = 1'b1;
    k      = cyc;
    for (int i = 0; i < 80; i++) begin
      tick();
      start2 = 1'b0;
      rel    = cyc - k;
      check("auto_odt", odt2, 1'b0);
      if (rel == 1)  check("auto_busy_rise", {busy2, rstn2, cke2}, 3'b100);
      if (rel == 9)  check("auto_rstn_rise", rstn2, 1'b1);
      if (rel == 23) check("auto_nop_23", {csn2, rasn2, casn2, wen2}, 4'b0111);
      if (rel == 24) check("auto_mr2", {csn2, rasn2, casn2, wen2, ba2, a2}, {4'b0000, 3'd2, 14'h0008});
      if (rel == 63) check("auto_done_63", {done2, busy2}, 2'b01);
      if (rel == 64) check("auto_done_64", {done2, busy2}, 2'b10);
      if (rel == 80) check("auto_done_hold", {done2, busy2, rstn2}, 3'b101);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ddr3_init_seq.md
Name: ddr3_init_seq

Overview:
- Power-up/initialisation sequencer for the 16-bit DDR3 device on the ddr3_* pins.
- Drives reset, CKE and the JEDEC init command stream: hold reset, wait for CKE, MRS to MR2, MR3, MR1 and MR0, then ZQCL.
- Then asserts init_done, so the memory controller can take over the command bus through a mux keyed on init_done.
- Sits beside the PCIe/GPIO logic in the top; clocked from osc.

Parameters:
- T_RESET_CYC, 10000, cycles ddr3_rstn held low after start (200 us at 50 MHz).
- T_CKE_CYC, 25000, cycles after rstn release with CKE low (500 us).
- T_XPR_CYC, 12, NOP cycles after CKE high before first MRS.
- T_MRD_CYC, 4, issue-to-issue spacing between consecutive MRS commands.
- T_MOD_CYC, 12, MR0 issue to ZQCL issue.
- T_ZQINIT_CYC, 512, ZQCL issue to init_done rise.
- MR0_VAL / MR1_VAL / MR2_VAL / MR3_VAL, 14'h0520 / 14'h0004 / 14'h0008 / 14'h0000, address-bus values for each mode register.
- AUTO_START, 1, 1 = begin the sequence on the first cycle after reset release without start.

Ports:
- osc  in  1  system clock, 50 MHz
- rst  in  1  asynchronous, active-high reset
- start  in  1  pulse; begins or restarts the sequence when not busy
- busy  out  1  high from the first sequencing cycle until init_done
- init_done  out  1  high once ZQ init is complete; held until reset or restart
- ddr3_rstn  out  1  DRAM RESET#
- ddr3_cke  out  1  clock enable
- ddr3_csn  out  1  chip select, active low
- ddr3_rasn  out  1  RAS#
- ddr3_casn  out  1  CAS#
- ddr3_wen  out  1  WE#
- ddr3_odt  out  1  ODT, held 0
- ddr3_a  out  14  address / MR value
- ddr3_ba  out  3  bank / MR index

Behaviour:
- Reset values (async, immediate on rst high, including mid-sequence):
  - rstn=0, cke=0, csn=1, rasn=casn=wen=1, a=0, ba=0, odt=0.
  - busy=0, init_done=0, state=IDLE.
- All outputs are registered.
- Command encodings:
  - DESELECT: csn=1.
  - NOP: csn=0, ras/cas/we=1.
  - MRS: csn=0, ras/cas/we=0, ba=MR index, a=MRn_VAL.
  - ZQCL: csn=0, ras=cas=1, we=0, a[10]=1, other a bits 0, ba=0.
- Each command is driven for exactly one cycle; cycles between commands are NOP once CKE is high, DESELECT before that.
- Timeline: trigger sampled in cycle 0 (start=1 in IDLE or DONE, or the first post-reset cycle when AUTO_START=1).
  - RST_HOLD: cycles 1..T_RESET_CYC; rstn=0, busy=1.
  - CKE_WAIT: next T_CKE_CYC cycles; rstn=1, cke=0.
  - XPR_WAIT: cke=1, T_XPR_CYC NOP cycles.
  - MRS2: issue MR2 (ba=2).
  - MRS3, MRS1, MRS0: each issued T_MRD_CYC after the previous MRS.
  - ZQCL: issued T_MOD_CYC after MR0.
  - ZQ_WAIT: runs until ZQCL issue + T_ZQINIT_CYC.
  - DONE: that cycle init_done=1, busy=0; bus parked at NOP, cke=1, rstn=1.
- State machine: IDLE, RST_HOLD, CKE_WAIT, XPR_WAIT, MRS2, MRS3, MRS1, MRS0, MOD_WAIT, ZQCL, ZQ_WAIT, DONE. Inter-MRS waits use a shared countdown.
- Single down-counter, width = clog2 of the largest T_* parameter + 1.
  - Loaded with (T − 1) on state entry; transition when it reaches 0.
  - Every T_* parameter must be ≥ 1; enforce with an elaboration-time check.
- start while busy is ignored.
- start in DONE restarts:
  - next cycle: init_done=0, busy=1, rstn=0, cke=0, csn=1; full sequence repeats.
- start and an AUTO_START trigger in the same cycle are a single trigger.
- ddr3_odt is constant 0 throughout.

Decomposition:
- Package ddr3_pkg holds:
  - state enum;
  - command encodings as {csn,rasn,casn,wen} constants (CMD_DESEL, CMD_NOP, CMD_MRS, CMD_ZQCL);
  - MR index constants.
- One sub-module is natural: ddr3_cmd_drv, the registered output stage that maps a command code plus a/ba onto the pins. It is reused later by the memory controller's command path.

Test Plan:
- Use T_RESET_CYC=8, T_CKE_CYC=10, T_XPR_CYC=5, T_MRD_CYC=4, T_MOD_CYC=12, T_ZQINIT_CYC=16, AUTO_START=0 unless noted.
- Basic sequence: start at cycle 0 ->
  - rstn low cycles 1–8, rises at 9; cke rises at 19;
  - MRS ba=2 at 24, ba=3 at 28, ba=1 at 32, ba=0 a=0x0520 at 36;
  - ZQCL (a=0x0400) at 48; init_done=1, busy=0 at 64.
- Auto start: AUTO_START=1, deassert rst at cycle 0 -> same timeline as basic, referenced to the first post-reset cycle; MR2 at cycle 24.
- Reset mid-sequence: assert rst at cycle 30 -> same cycle, all outputs return to reset values; after rst release plus start, MR2 appears 24 cycles after the trigger.
- Start while busy: pulse start at cycle 15 and 40 -> no timeline change; init_done still at 64.
- Restart from DONE: start at cycle 70 -> cycle 71: init_done=0, busy=1, rstn=0; second init_done at cycle 134.
- Idle bus: between commands after cke=1, exactly NOP (csn=0, ras/cas/we=1); odt=0 all cycles; exactly 5 commands issued per sequence.
